// File: rtl/correction_unloader_if.sv
// Result-side bundle for correction_unloader: decode-result capture inputs,
// the outgoing valid/ready word stream, and the busy/overflow status flags.
interface correction_unloader_if #(
  parameter int CORRECTION_COUNT = 57,
  parameter int DATA_WIDTH       = 32
);
  logic                        result_valid;
  logic [CORRECTION_COUNT-1:0] correction;
  logic [7:0]                  iteration_counter;
  logic [31:0]                 cycle_counter;
  logic [DATA_WIDTH-1:0]       out_data;
  logic                        out_valid;
  logic                        out_ready;
  logic                        out_last;
  logic                        busy;
  logic                        overflow;

  // master is the unloader itself; slave is the controller/host side
  modport master (
    input  result_valid, correction, iteration_counter, cycle_counter, out_ready,
    output out_data, out_valid, out_last, busy, overflow
  );

  modport slave (
    output result_valid, correction, iteration_counter, cycle_counter, out_ready,
    input  out_data, out_valid, out_last, busy, overflow
  );
endinterface

// File: rtl/correction_unloader.sv
// Snapshots one decode result and streams it as HDR0, HDR1, payload words [, trailer].
// Optional checksum trailer beat: define CORRECTION_UNLOADER_TRAILER_EN.
module correction_unloader #(
  parameter int CODE_DISTANCE_X = 3,
  parameter int CODE_DISTANCE_Z = 2,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  correction_unloader_if.master bus
);
  localparam int MR = (CODE_DISTANCE_X > CODE_DISTANCE_Z) ? CODE_DISTANCE_X : CODE_DISTANCE_Z;
  localparam int CC = (CODE_DISTANCE_X - 1) * CODE_DISTANCE_Z * MR
                    + CODE_DISTANCE_X * (CODE_DISTANCE_Z + 1) * MR
                    + CODE_DISTANCE_X * CODE_DISTANCE_Z * MR;
  localparam int PW = (CC + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int BW = (PW > 1) ? $clog2(PW) : 1;
  localparam logic [BW-1:0] LAST_IDX = BW'(PW - 1);

`ifdef CORRECTION_UNLOADER_TRAILER_EN
  localparam bit HAS_TRAILER = 1'b1;
  logic [DATA_WIDTH-1:0] r_csum;
`else
  localparam bit HAS_TRAILER = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_HDR0, S_HDR1, S_PAYLOAD, S_TRAILER} state_t;

  state_t                r_state;
  logic [CC-1:0]         r_snap;
  logic [31:0]           r_cycle;
  logic [15:0]           r_frameId;
  logic [BW-1:0]         r_beat;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_last;
  logic                  r_busy;
  logic                  r_overflow;

  logic                       w_fire;
  logic                       w_finalFire;
  logic                       w_accept;
  logic [BW-1:0]              w_nextIdx;
  logic [DATA_WIDTH-1:0]      w_hdr0;
  logic [DATA_WIDTH-1:0]      w_hdr1;
  logic [PW*DATA_WIDTH-1:0]   w_padded;
  logic [DATA_WIDTH-1:0]      w_words [PW];

  assign w_fire      = r_valid && bus.out_ready;
  assign w_finalFire = w_fire && r_last;
  // A new result is taken when idle or exactly on the closing handshake of a frame
  assign w_accept    = bus.result_valid && ((r_state == S_IDLE) || w_finalFire);
  assign w_nextIdx   = r_beat + BW'(1);

  always_comb begin
    w_hdr0         = '0;
    w_hdr0[31:0]   = {r_frameId, 8'h00, bus.iteration_counter};
    w_hdr1         = '0;
    w_hdr1[31:0]   = r_cycle;
    w_padded       = '0;
    w_padded[CC-1:0] = r_snap;
    for (int k = 0; k < PW; k++) begin
      w_words[k] = w_padded[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_snap     <= '0;
      r_cycle    <= '0;
      r_frameId  <= '0;
      r_beat     <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
`ifdef CORRECTION_UNLOADER_TRAILER_EN
      r_csum     <= '0;
`endif
    end else begin
      if (bus.result_valid && !w_accept) begin
        r_overflow <= 1'b1;
      end

      if (w_accept) begin
        r_snap    <= bus.correction;
        r_cycle   <= bus.cycle_counter;
        r_frameId <= r_frameId + 16'd1;
        r_data    <= w_hdr0;
        r_valid   <= 1'b1;
        r_last    <= 1'b0;
        r_busy    <= 1'b1;
        r_beat    <= '0;
        r_state   <= S_HDR0;
`ifdef CORRECTION_UNLOADER_TRAILER_EN
        r_csum    <= w_hdr0;
`endif
      end else if (w_finalFire) begin
        r_state <= S_IDLE;
        r_data  <= '0;
        r_valid <= 1'b0;
        r_last  <= 1'b0;
        r_busy  <= 1'b0;
      end else if (w_fire) begin
        // r_csum always holds the XOR of every word already placed on out_data
        case (r_state)
          S_HDR0: begin
            r_state <= S_HDR1;
            r_data  <= w_hdr1;
`ifdef CORRECTION_UNLOADER_TRAILER_EN
            r_csum  <= r_csum ^ w_hdr1;
`endif
          end
          S_HDR1: begin
            r_state <= S_PAYLOAD;
            r_beat  <= '0;
            r_data  <= w_words[0];
            r_last  <= !HAS_TRAILER && (PW == 1);
`ifdef CORRECTION_UNLOADER_TRAILER_EN
            r_csum  <= r_csum ^ w_words[0];
`endif
          end
          S_PAYLOAD: begin
            if (r_beat == LAST_IDX) begin
`ifdef CORRECTION_UNLOADER_TRAILER_EN
              r_state <= S_TRAILER;
              r_data  <= r_csum;
              r_last  <= 1'b1;
`endif
            end else begin
              r_beat <= w_nextIdx;
              r_data <= w_words[w_nextIdx];
              r_last <= !HAS_TRAILER && (w_nextIdx == LAST_IDX);
`ifdef CORRECTION_UNLOADER_TRAILER_EN
              r_csum <= r_csum ^ w_words[w_nextIdx];
`endif
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.out_data  = r_data;
  assign bus.out_valid = r_valid;
  assign bus.out_last  = r_last;
  assign bus.busy      = r_busy;
  assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_correction_unloader.sv
// Scoreboard bench for correction_unloader at default parameters (57-bit vector, 32-bit words).
// Stimulus pushes expected beats; a negedge monitor pops and compares each handshake.
module tb_correction_unloader;
`ifdef CORRECTION_UNLOADER_TRAILER_EN
  localparam bit TB_TRAILER = 1'b1;
`else
  localparam bit TB_TRAILER = 1'b0;
`endif
  localparam int FRAME_BEATS = TB_TRAILER ? 5 : 4;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  logic [15:0] expFid;
  beat_t expQ[$];

  correction_unloader_if #(.CORRECTION_COUNT(57), .DATA_WIDTH(32)) ifc();

  correction_unloader #(
    .CODE_DISTANCE_X(3),
    .CODE_DISTANCE_Z(2),
    .DATA_WIDTH(32)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Hand model of one frame: header words, payload split low word first, optional XOR trailer
  function automatic void pushFrame(input logic [15:0] fid, input logic [7:0] iter,
                                    input logic [31:0] cyc, input logic [56:0] corr);
    logic [31:0] w [4];
    logic [63:0] padded;
    logic [31:0] x;
    beat_t b;
    padded = {7'b0, corr};
    w[0] = {fid, 8'h00, iter};
    w[1] = cyc;
    w[2] = padded[31:0];
    w[3] = padded[63:32];
    x = 32'h0;
    for (int i = 0; i < 4; i++) begin
      b.data = w[i];
      b.last = (i == 3) && !TB_TRAILER;
      expQ.push_back(b);
      x = x ^ w[i];
    end
    if (TB_TRAILER) begin
      b.data = x;
      b.last = 1'b1;
      expQ.push_back(b);
    end
  endfunction

  task automatic applyStimulus(input logic [7:0] iter, input logic [31:0] cyc,
                               input logic [56:0] corr, input bit expectAccept);
    ifc.result_valid      = 1'b1;
    ifc.iteration_counter = iter;
    ifc.cycle_counter     = cyc;
    ifc.correction        = corr;
    if (expectAccept) begin
      pushFrame(expFid, iter, cyc, corr);
      expFid = expFid + 16'd1;
    end
    @(posedge clk);
    #1;
    ifc.result_valid      = 1'b0;
    ifc.iteration_counter = ~iter;
    ifc.cycle_counter     = ~cyc;
    ifc.correction        = ~corr;
  endtask

  task automatic waitDrain(input bit toggle, input int limit);
    int n;
    n = 0;
    while ((expQ.size() != 0 || ifc.out_valid) && n < limit) begin
      @(posedge clk);
      #1;
      if (toggle) ifc.out_ready = ~ifc.out_ready;
      n++;
    end
    vectors++;
    if (expQ.size() != 0 || ifc.out_valid) begin
      miscompares++;
      $display("[TB] FAIL drain: %0d beats still expected, out_valid=%0b after %0d cycles",
               expQ.size(), ifc.out_valid, n);
    end
    ifc.out_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted beat must match the head of the expected queue
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (!reset && ifc.out_valid && ifc.out_ready) begin
        if (expQ.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected beat: got data 0x%0h last %0b, expected none",
                   ifc.out_data, ifc.out_last);
        end else begin
          e = expQ.pop_front();
          checkOutput("beat data", 64'(ifc.out_data), 64'(e.data));
          checkOutput("beat last", 64'(ifc.out_last), 64'(e.last));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    vectors     = 0;
    miscompares = 0;
    expFid      = 16'h0000;
    reset                 = 1'b1;
    ifc.result_valid      = 1'b0;
    ifc.correction        = '0;
    ifc.iteration_counter = 8'h00;
    ifc.cycle_counter     = 32'h0;
    ifc.out_ready         = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] reset state");
    checkOutput("reset out_valid", 64'(ifc.out_valid), 64'd0);
    checkOutput("reset out_last", 64'(ifc.out_last), 64'd0);
    checkOutput("reset out_data", 64'(ifc.out_data), 64'd0);
    checkOutput("reset busy", 64'(ifc.busy), 64'd0);
    checkOutput("reset overflow", 64'(ifc.overflow), 64'd0);

    $display("[TB] basic frame, ready held high");
    applyStimulus(8'd5, 32'd100, 57'h1, 1'b1);
    checkOutput("capture latency out_valid", 64'(ifc.out_valid), 64'd1);
    checkOutput("capture busy", 64'(ifc.busy), 64'd1);
    waitDrain(1'b0, 20);
    checkOutput("idle busy", 64'(ifc.busy), 64'd0);

    $display("[TB] frame with out_ready toggling");
    applyStimulus(8'h2A, 32'hDEADBEEF, 57'h0AB_CDEF_0123_4567, 1'b1);
    waitDrain(1'b1, 40);

    $display("[TB] back-to-back capture on final handshake");
    applyStimulus(8'h11, 32'h0000_1234, 57'h1FF_FFFF_FFFF_FFFF, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ifc.out_last && n < 20);
    checkOutput("final beat reached", 64'(ifc.out_last), 64'd1);
    applyStimulus(8'h22, 32'h0000_5678, 57'h100_0000_8000_0001, 1'b1);
    checkOutput("b2b out_valid", 64'(ifc.out_valid), 64'd1);
    checkOutput("b2b busy", 64'(ifc.busy), 64'd1);
    checkOutput("b2b overflow", 64'(ifc.overflow), 64'd0);
    waitDrain(1'b0, 30);

    $display("[TB] result during HDR1 is dropped");
    applyStimulus(8'h33, 32'hCAFE_F00D, 57'h0F0_F0F0_F0F0_F0F0, 1'b1);
    @(posedge clk);
    #1;
    applyStimulus(8'h44, 32'h1111_2222, 57'h155_5555_5555_5555, 1'b0);
    checkOutput("overflow set", 64'(ifc.overflow), 64'd1);
    checkOutput("frame continues", 64'(ifc.out_valid), 64'd1);
    waitDrain(1'b0, 20);
    checkOutput("overflow sticky", 64'(ifc.overflow), 64'd1);
    applyStimulus(8'h55, 32'h0000_0007, 57'h000_0000_0000_00FF, 1'b1);
    waitDrain(1'b0, 20);

    $display("[TB] frame id wrap");
    force dut.r_frameId = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.r_frameId;
    @(posedge clk);
    #1;
    expFid = 16'hFFFF;
    applyStimulus(8'h66, 32'h0000_0042, 57'h000_0001_0000_0000, 1'b1);
    waitDrain(1'b0, 20);
    applyStimulus(8'h77, 32'h0000_0043, 57'h000_0000_0000_0002, 1'b1);
    waitDrain(1'b0, 20);

    $display("[TB] reset during first payload beat");
    applyStimulus(8'h88, 32'h0000_0099, 57'h0AA_0000_0000_00BB, 1'b1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("abort out_valid", 64'(ifc.out_valid), 64'd0);
    checkOutput("abort out_last", 64'(ifc.out_last), 64'd0);
    checkOutput("abort busy", 64'(ifc.busy), 64'd0);
    checkOutput("abort overflow", 64'(ifc.overflow), 64'd0);
    checkOutput("abort beats left", 64'(expQ.size()), 64'(FRAME_BEATS - 2));
    expQ.delete();
    expFid = 16'h0000;
    applyStimulus(8'h99, 32'h0000_0123, 57'h000_0000_0000_0003, 1'b1);
    waitDrain(1'b0, 20);

    checkOutput("queue empty at end", 64'(expQ.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
